cpu_addr_seq: RTL and testbench



---
 rtl/cpu_addr_seq_pkg.sv | 46 ++++
 rtl/cpu_ea_adder.sv | 25 ++
 rtl/cpu_addr_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_cpu_addr_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_addr_seq_pkg.sv
// Shared constants for the 6502 address sequencer: addressing-mode codes,
// index select codes, the sequencer state encoding and a small index helper.
package cpu_addr_seq_pkg;

    // Address of the reset vector low byte; the high byte follows it.
    localparam logic [15:0] RESET_VEC = 16'hFFFC;

    // Decoded addressing modes presented on adr_mode.
    localparam logic [3:0] ADR_IMPL  = 4'd0;
    localparam logic [3:0] ADR_IMM   = 4'd1;
    localparam logic [3:0] ADR_REL   = 4'd2;
    localparam logic [3:0] ADR_ZPG   = 4'd3;
    localparam logic [3:0] ADR_ZPG_I = 4'd4;
    localparam logic [3:0] ADR_ABS   = 4'd5;
    localparam logic [3:0] ADR_ABS_I = 4'd6;
    localparam logic [3:0] ADR_IND   = 4'd7;
    localparam logic [3:0] ADR_X_IND = 4'd8;
    localparam logic [3:0] ADR_IND_Y = 4'd9;
    localparam logic [3:0] ADR_INVAL = 4'hF;

    // Index register select.
    localparam logic ADR_INDEX_X = 1'b0;
    localparam logic ADR_INDEX_Y = 1'b1;

    // Instruction-cycle states.
    typedef enum logic [3:0] {
        ST_VEC0,
        ST_VEC1,
        ST_FETCH,
        ST_DEC,
        ST_OP2,
        ST_PTR0,
        ST_PTR1,
        ST_ACCESS,
        ST_BRA,
        ST_HALT
    } state_t;

    // Picks the index register named by the decode index bit.
    function automatic logic [7:0] sel_index(input logic       index,
                                             input logic [7:0] x_val,
                                             input logic [7:0] y_val);
        return (index == ADR_INDEX_Y) ? y_val : x_val;
    endfunction

endpackage

// File: rtl/cpu_ea_adder.sv
// Effective-address adder: 16-bit base plus an 8-bit index or branch offset.
// Zero-page mode wraps inside page 0; signed mode sign-extends the offset.
module cpu_ea_adder (
    input  logic [15:0] i_base,
    input  logic [7:0]  i_off,
    input  logic        i_zp_wrap,
    input  logic        i_signed,
    output logic [15:0] o_sum
);

    logic [15:0] w_off_ext;
    logic [7:0]  w_zp_lo;

    // Extend the 8-bit operand to 16 bits (sign-extended for branch offsets).
    always_comb begin
        w_off_ext = {8'h00, i_off};
        if (i_signed) begin
            w_off_ext = {{8{i_off[7]}}, i_off};
        end
    end

    assign w_zp_lo = i_base[7:0] + i_off;
    assign o_sum   = i_zp_wrap ? {8'h00, w_zp_lo} : (i_base + w_off_ext);

endmodule

// File: rtl/cpu_addr_seq.sv
// 6502 instruction-cycle sequencer: opcode fetch, operand fetch, effective
// address formation for each addressing mode and the final memory access.
// Bus outputs are decoded from the current state so data_in is valid in the
// same cycle as addr.
module cpu_addr_seq
    import cpu_addr_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rdy,
    input  logic [3:0]  i_adr_mode,
    input  logic        i_index,
    input  logic        i_from_mem,
    input  logic        i_to_mem,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_branch_taken,
    input  logic [7:0]  i_x_reg,
    input  logic [7:0]  i_y_reg,
    input  logic [7:0]  i_data_in,
    output logic [15:0] o_addr,
    output logic        o_rw,
    output logic        o_sync,
    output logic        o_ir_load,
    output logic        o_mem_valid,
    output logic        o_exec,
    output logic        o_halt,
    output logic [15:0] o_pc
);

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [7:0]  r_lo, w_lo_next;     // vector low / operand low / pointer low byte
    logic [15:0] r_ea, w_ea_next;
    logic [15:0] r_ptr, w_ptr_next;
    logic [3:0]  r_mode, w_mode_next;

    logic [15:0] w_addr;
    logic        w_rw, w_sync, w_mv, w_exec, w_halt;

    logic [7:0]  w_idx;
    logic [15:0] w_add_base, w_add_sum;
    logic [7:0]  w_add_off;
    logic        w_add_zp, w_add_signed;

    // Qualifiers carried on the decode bus that this sequencer does not need.
    logic w_unused;
    assign w_unused = i_from_mem ^ i_branch;

    assign w_idx = sel_index(i_index, i_x_reg, i_y_reg);

    // Route the adder operands for whichever state needs an address sum.
    always_comb begin
        w_add_base   = r_pc;
        w_add_off    = 8'h00;
        w_add_zp     = 1'b0;
        w_add_signed = 1'b0;
        case (r_state)
            ST_DEC: begin
                w_add_base = {8'h00, i_data_in};
                w_add_off  = (i_adr_mode == ADR_X_IND) ? i_x_reg : w_idx;
                w_add_zp   = 1'b1;
            end
            ST_OP2: begin
                w_add_base = {i_data_in, r_lo};
                w_add_off  = w_idx;
            end
            ST_PTR1: begin
                w_add_base = {i_data_in, r_lo};
                w_add_off  = i_y_reg;
            end
            ST_BRA: begin
                w_add_base   = r_pc;
                w_add_off    = r_lo;
                w_add_signed = 1'b1;
            end
            default: ;
        endcase
    end

    cpu_ea_adder u_ea_adder (
        .i_base    (w_add_base),
        .i_off     (w_add_off),
        .i_zp_wrap (w_add_zp),
        .i_signed  (w_add_signed),
        .o_sum     (w_add_sum)
    );

    // Next-state, register updates and bus outputs for the current state.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_lo_next    = r_lo;
        w_ea_next    = r_ea;
        w_ptr_next   = r_ptr;
        w_mode_next  = r_mode;
        w_addr       = r_pc;
        w_rw         = 1'b1;
        w_sync       = 1'b0;
        w_mv         = 1'b0;
        w_exec       = 1'b0;
        w_halt       = 1'b0;
        case (r_state)
            ST_VEC0: begin
                w_addr       = RESET_VEC;
                w_lo_next    = i_data_in;
                w_state_next = ST_VEC1;
            end
            ST_VEC1: begin
                w_addr       = RESET_VEC + 16'd1;
                w_pc_next    = {i_data_in, r_lo};
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_sync       = 1'b1;
                w_pc_next    = r_pc + 16'd1;
                w_state_next = ST_DEC;
            end
            ST_DEC: begin
                w_mode_next = i_adr_mode;
                w_lo_next   = i_data_in;
                w_pc_next   = r_pc + 16'd1;
                case (i_adr_mode)
                    ADR_IMPL: begin
                        w_exec       = 1'b1;
                        w_lo_next    = r_lo;
                        w_pc_next    = r_pc;
                        w_state_next = ST_FETCH;
                    end
                    ADR_IMM: begin
                        w_mv         = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    ADR_REL: begin
                        w_state_next = i_branch_taken ? ST_BRA : ST_FETCH;
                    end
                    ADR_ZPG: begin
                        w_ea_next    = {8'h00, i_data_in};
                        w_state_next = ST_ACCESS;
                    end
                    ADR_ZPG_I: begin
                        w_ea_next    = w_add_sum;
                        w_state_next = ST_ACCESS;
                    end
                    ADR_X_IND: begin
                        w_ptr_next   = w_add_sum;
                        w_state_next = ST_PTR0;
                    end
                    ADR_IND_Y: begin
                        w_ptr_next   = {8'h00, i_data_in};
                        w_state_next = ST_PTR0;
                    end
                    ADR_ABS, ADR_ABS_I, ADR_IND: begin
                        w_state_next = ST_OP2;
                    end
                    default: begin
                        // Unknown or invalid opcode: trap without consuming an operand.
                        w_lo_next    = r_lo;
                        w_pc_next    = r_pc;
                        w_state_next = ST_HALT;
                    end
                endcase
            end
            ST_OP2: begin
                w_pc_next = r_pc + 16'd1;
                if (r_mode == ADR_IND) begin
                    w_ptr_next   = {i_data_in, r_lo};
                    w_state_next = ST_PTR0;
                end else begin
                    w_ea_next = (r_mode == ADR_ABS_I) ? w_add_sum : {i_data_in, r_lo};
                    if (i_jump) begin
                        w_pc_next    = w_ea_next;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_ACCESS;
                    end
                end
            end
            ST_PTR0: begin
                w_addr       = r_ptr;
                w_lo_next    = i_data_in;
                w_state_next = ST_PTR1;
            end
            ST_PTR1: begin
                // Low byte increments without carry: page wrap as on the NMOS part.
                w_addr    = {r_ptr[15:8], r_ptr[7:0] + 8'd1};
                w_ea_next = (r_mode == ADR_IND_Y) ? w_add_sum : {i_data_in, r_lo};
                if ((r_mode == ADR_IND) && i_jump) begin
                    w_pc_next    = w_ea_next;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_addr = r_ea;
                if (i_to_mem) begin
                    w_rw = 1'b0;
                end else begin
                    w_mv = 1'b1;
                end
                w_state_next = ST_FETCH;
            end
            ST_BRA: begin
                w_pc_next    = w_add_sum;
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                w_halt = 1'b1;
            end
            default: begin
                w_state_next = ST_VEC0;
            end
        endcase
    end

    // State and latch registers; reset wins over everything, rdy low freezes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_VEC0;
            r_pc    <= 16'h0000;
            r_lo    <= 8'h00;
            r_ea    <= 16'h0000;
            r_ptr   <= 16'h0000;
            r_mode  <= ADR_IMPL;
        end else if (i_rdy) begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_lo    <= w_lo_next;
            r_ea    <= w_ea_next;
            r_ptr   <= w_ptr_next;
            r_mode  <= w_mode_next;
        end
    end

    assign o_addr      = w_addr;
    assign o_rw        = w_rw;
    assign o_sync      = w_sync & i_rdy;
    assign o_ir_load   = w_sync & i_rdy;
    assign o_mem_valid = w_mv & i_rdy;
    assign o_exec      = w_exec & i_rdy;
    assign o_halt      = w_halt;
    assign o_pc        = r_pc;

endmodule

// File: tb/tb_cpu_addr_seq.sv
module tb_cpu_addr_seq;
    import cpu_addr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [3:0]  adr_mode;
    logic        index, from_mem, to_mem, branch, jump, branch_taken;
    logic [7:0]  x_reg, y_reg, data_in;
    logic [15:0] addr, pc;
    logic        rw, sync, ir_load, mem_valid, exec, halt;

    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;

    assign data_in = mem[addr];

    cpu_addr_seq dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rdy          (rdy),
        .i_adr_mode     (adr_mode),
        .i_index        (index),
        .i_from_mem     (from_mem),
        .i_to_mem       (to_mem),
        .i_branch       (branch),
        .i_jump         (jump),
        .i_branch_taken (branch_taken),
        .i_x_reg        (x_reg),
        .i_y_reg        (y_reg),
        .i_data_in      (data_in),
        .o_addr         (addr),
        .o_rw           (rw),
        .o_sync         (sync),
        .o_ir_load      (ir_load),
        .o_mem_valid    (mem_valid),
        .o_exec         (exec),
        .o_halt         (halt),
        .o_pc           (pc)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        a_chk;
        logic        rw;
        logic        sy;
        logic        mv;
        logic        ex;
        logic        hl;
        logic        pc_chk;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rec_n  = 0;

    task automatic cy(input logic [15:0] a, input logic ac, input logic r,
                      input logic s, input logic m, input logic e, input logic h,
                      input logic pcc, input logic [15:0] p);
        exp_t rec;
        rec.addr = a; rec.a_chk = ac; rec.rw = r; rec.sy = s; rec.mv = m;
        rec.ex = e; rec.hl = h; rec.pc_chk = pcc; rec.pc = p;
        exp_q.push_back(rec);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] a); cy(a, 1, 1, 1, 0, 0, 0, 1, a); endtask
    task automatic rd(input logic [15:0] a);    cy(a, 1, 1, 0, 0, 0, 0, 0, 16'h0); endtask
    task automatic mvr(input logic [15:0] a);   cy(a, 1, 1, 0, 1, 0, 0, 0, 16'h0); endtask
    task automatic wr(input logic [15:0] a);    cy(a, 1, 0, 0, 0, 0, 0, 0, 16'h0); endtask
    task automatic nb();                        cy(16'h0, 0, 1, 0, 0, 0, 0, 0, 16'h0); endtask

    task automatic set_dec(input logic [3:0] m, input logic ix, input logic tm,
                           input logic jp, input logic br, input logic tk);
        adr_mode = m; index = ix; to_mem = tm; from_mem = ~tm;
        jump = jp; branch = br; branch_taken = tk;
    endtask

    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ok = (rw === e.rw) && (sync === e.sy) && (ir_load === e.sy) &&
                     (mem_valid === e.mv) && (exec === e.ex) && (halt === e.hl) &&
                     (!e.a_chk || (addr === e.addr)) && (!e.pc_chk || (pc === e.pc));
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rec%0d: got addr=%h rw=%b sync=%b ir=%b mv=%b exec=%b halt=%b pc=%h; need addr=%h(chk %b) rw=%b sync=%b mv=%b exec=%b halt=%b pc=%h(chk %b)",
                             rec_n, addr, rw, sync, ir_load, mem_valid, exec, halt, pc,
                             e.addr, e.a_chk, e.rw, e.sy, e.mv, e.ex, e.hl, e.pc, e.pc_chk);
                end else begin
                    $display("rec%0d ok: addr=%h rw=%b sync=%b mv=%b exec=%b halt=%b pc=%h",
                             rec_n, addr, rw, sync, mem_valid, exec, halt, pc);
                end
                rec_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, need end before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8001] = 8'hFC; mem[16'h7FFF] = 8'h10; mem[16'h8003] = 8'h42;
        mem[16'h8005] = 8'hF0; mem[16'h8006] = 8'h12;
        mem[16'h8008] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h800A] = 8'hFF; mem[16'h800B] = 8'h10;
        mem[16'h10FF] = 8'h00; mem[16'h1000] = 8'h90; mem[16'h1100] = 8'h77;
        mem[16'h9001] = 8'hF0; mem[16'h9003] = 8'hFE;
        mem[16'h0003] = 8'h78; mem[16'h0004] = 8'h56;
        mem[16'h9005] = 8'h56; mem[16'h9006] = 8'h34;
        mem[16'h9009] = 8'h00; mem[16'h900A] = 8'h20;

        rst = 1'b1; rdy = 1'b1; x_reg = 8'h00; y_reg = 8'h00;
        set_dec(ADR_IMPL, ADR_INDEX_X, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        rst = 1'b0;
        cy(16'hFFFC, 1, 1, 0, 0, 0, 0, 1, 16'h0000);
        cy(16'hFFFD, 1, 1, 0, 0, 0, 0, 0, 16'h0);

        set_dec(ADR_REL, ADR_INDEX_X, 0, 0, 1, 1);
        fetch(16'h8000); rd(16'h8001); nb();
        checks++;
        if (pc !== 16'h7FFE) begin
            errors++;
            $display("FAIL bra taken: got pc=%h, need 7ffe", pc);
        end else begin
            $display("bra taken ok: pc=%h", pc);
        end

        set_dec(ADR_REL, ADR_INDEX_X, 0, 0, 1, 0);
        fetch(16'h7FFE); rd(16'h7FFF);
        fetch(16'h8000); rd(16'h8001);
        checks++;
        if (pc !== 16'h8002) begin
            errors++;
            $display("FAIL bra not taken: got pc=%h, need 8002", pc);
        end else begin
            $display("bra not taken ok: pc=%h", pc);
        end

        set_dec(ADR_IMM, ADR_INDEX_X, 0, 0, 0, 0);
        fetch(16'h8002);
        checks++;
        if (data_in !== 8'h42) begin
            errors++;
            $display("FAIL imm data: got data_in=%h, need 42", data_in);
        end else begin
            $display("imm data ok: data_in=%h", data_in);
        end
        mvr(16'h8003);

        x_reg = 8'h20;
        set_dec(ADR_ABS_I, ADR_INDEX_X, 1, 0, 0, 0);
        fetch(16'h8004); rd(16'h8005); rd(16'h8006); wr(16'h1310);

        y_reg = 8'h10;
        set_dec(ADR_IND_Y, ADR_INDEX_Y, 0, 0, 0, 0);
        fetch(16'h8007); rd(16'h8008); rd(16'h00FF); rd(16'h0000); mvr(16'h1244);

        set_dec(ADR_IND, ADR_INDEX_X, 0, 1, 0, 0);
        fetch(16'h8009); rd(16'h800A); rd(16'h800B); rd(16'h10FF); rd(16'h1000);
        checks++;
        if (pc !== 16'h9000) begin
            errors++;
            $display("FAIL jmp ind: got pc=%h, need 9000", pc);
        end else begin
            $display("jmp ind ok: pc=%h", pc);
        end

        set_dec(ADR_ZPG_I, ADR_INDEX_X, 0, 0, 0, 0);
        fetch(16'h9000); rd(16'h9001); mvr(16'h0010);

        x_reg = 8'h05;
        set_dec(ADR_X_IND, ADR_INDEX_X, 0, 0, 0, 0);
        fetch(16'h9002); rd(16'h9003); rd(16'h0003); rd(16'h0004); mvr(16'h5678);

        set_dec(ADR_ABS, ADR_INDEX_X, 0, 0, 0, 0);
        fetch(16'h9004); rd(16'h9005);
        rdy = 1'b0; rd(16'h9006); rd(16'h9006);
        checks++;
        if (addr !== 16'h9006) begin
            errors++;
            $display("FAIL stall hold: got addr=%h, need 9006", addr);
        end else begin
            $display("stall hold ok: addr=%h", addr);
        end
        rd(16'h9006);
        rdy = 1'b1; rd(16'h9006); mvr(16'h3456);

        set_dec(ADR_IMPL, ADR_INDEX_X, 0, 0, 0, 0);
        rdy = 1'b0; cy(16'h9007, 1, 1, 0, 0, 0, 0, 1, 16'h9007);
        rdy = 1'b1; fetch(16'h9007); cy(16'h0, 0, 1, 0, 0, 1, 0, 1, 16'h9008);

        set_dec(ADR_ABS, ADR_INDEX_X, 1, 0, 0, 0);
        fetch(16'h9008); rd(16'h9009); rd(16'h900A);
        rst = 1'b1; wr(16'h2000);
        checks++;
        if (addr !== 16'hFFFC) begin
            errors++;
            $display("FAIL reset mid access: got addr=%h, need fffc", addr);
        end else begin
            $display("reset mid access ok: addr=%h", addr);
        end
        rst = 1'b0; cy(16'hFFFC, 1, 1, 0, 0, 0, 0, 1, 16'h0000);
        cy(16'hFFFD, 1, 1, 0, 0, 0, 0, 0, 16'h0);

        set_dec(ADR_INVAL, ADR_INDEX_X, 0, 0, 0, 0);
        fetch(16'h8000); nb();
        cy(16'h0, 0, 1, 0, 0, 0, 1, 1, 16'h8001);
        cy(16'h0, 0, 1, 0, 0, 0, 1, 1, 16'h8001);
        cy(16'h0, 0, 1, 0, 0, 0, 1, 1, 16'h8001);
        checks++;
        if (halt !== 1'b1) begin
            errors++;
            $display("FAIL halt hold: got halt=%b, need 1", halt);
        end else begin
            $display("halt hold ok: halt=%b", halt);
        end
        rst = 1'b1; cy(16'h0, 0, 1, 0, 0, 0, 1, 1, 16'h8001);
        rst = 1'b0; cy(16'hFFFC, 1, 1, 0, 0, 0, 0, 1, 16'h0000);
        cy(16'hFFFD, 1, 1, 0, 0, 0, 0, 0, 16'h0);

        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
